// File: rtl/apb_sd_spi_pkg.sv
// Shared constants for the APB SD-card SPI master: register offsets, pad map,
// engine state encoding and the transfer length limit.
package apb_sd_spi_pkg;

    localparam logic [7:0] OFF_OUT    = 8'h40;
    localparam logic [7:0] OFF_DIR    = 8'h44;
    localparam logic [7:0] OFF_PIN    = 8'h48;
    localparam logic [7:0] OFF_DATA   = 8'h4C;
    localparam logic [7:0] OFF_CNT    = 8'h50;
    localparam logic [7:0] OFF_STATUS = 8'h54;
    localparam logic [7:0] OFF_DIV    = 8'h58;

    localparam int PAD_MISO = 0;
    localparam int PAD_MOSI = 1;
    localparam int PAD_SCK  = 2;
    localparam int PAD_CS   = 3;
    localparam int PAD_D2   = 4;
    localparam int PAD_D1   = 5;

    typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOW  = LOW;
    localparam logic [1:0] ST_HIGH = HIGH;

    localparam logic [5:0] MAX_CNT = 6'd32;

    function automatic logic [5:0] clamp_cnt(input logic [5:0] n);
        return (n > MAX_CNT) ? MAX_CNT : n;
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 shift engine: MSB-first transmit, LSB-in receive, half period of
// div+1 clock cycles. The FSM state is exported on the state output.
module spi_shift_engine
    import apb_sd_spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  n,
    input  logic [31:0] tx,
    input  logic [7:0]  div,
    input  logic        done_clr,
    input  logic        miso,
    output logic        busy,
    output logic        done,
    output logic [31:0] rx,
    output logic        sck,
    output logic        mosi,
    output logic [5:0]  remaining,
    output logic [1:0]  state
);

    logic [7:0]  half_cnt;
    logic [31:0] tx_sh;
    logic [5:0]  bits_left;
    logic        half_end;

    assign half_end = (half_cnt == div);

    // tx is left-aligned on start so the current bit is always tx_sh[31];
    // no shift happens after the last bit, so MOSI holds it when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            half_cnt  <= 8'd0;
            tx_sh     <= 32'd0;
            rx        <= 32'd0;
            bits_left <= 6'd0;
            done      <= 1'b0;
        end else begin
            if (done_clr) done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_LOW;
                        bits_left <= n;
                        tx_sh     <= tx << (MAX_CNT - n);
                        rx        <= 32'd0;
                        done      <= 1'b0;
                        half_cnt  <= 8'd0;
                    end
                end
                ST_LOW: begin
                    if (half_end) begin
                        half_cnt <= 8'd0;
                        state    <= ST_HIGH;
                        rx       <= {rx[30:0], miso};
                    end else begin
                        half_cnt <= half_cnt + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (half_end) begin
                        half_cnt  <= 8'd0;
                        bits_left <= bits_left - 6'd1;
                        if (bits_left == 6'd1) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_LOW;
                            tx_sh <= {tx_sh[30:0], 1'b0};
                        end
                    end else begin
                        half_cnt <= half_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign sck       = (state == ST_HIGH);
    assign mosi      = tx_sh[31];
    assign remaining = bits_left;

endmodule

// File: rtl/apb_sd_spi.sv
// APB-attached SD-card SPI master with raw pad GPIO. Optional clock divider
// register is enabled by defining APB_SD_SPI_CLKDIV_EN.
module apb_sd_spi
    import apb_sd_spi_pkg::*;
#(
    parameter int PAD_W = 6
) (
    input  logic             clk,
    input  logic             cpu_reset_n,
    input  logic [7:0]       PADDR,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic [PAD_W-1:0] pad_out,
    output logic [PAD_W-1:0] pad_oe,
    input  logic [PAD_W-1:0] pad_in
);

    localparam int ZW = 32 - PAD_W;

    // Handshake: an access completes in its access phase (PSEL & PENABLE);
    // PREADY is held high, so every access takes exactly one access cycle.
    logic wr, rd;
    assign wr     = PSEL & PENABLE & PWRITE;
    assign rd     = PSEL & PENABLE & ~PWRITE;
    assign PREADY = 1'b1;

    logic [PAD_W-1:0] out_q, dir_q, pin_s1, pin_s2;
    logic [31:0]      tx_q, rx;
    logic [7:0]       div;
    logic [5:0]       remaining;
    logic [1:0]       eng_state;
    logic             busy, done, sck, mosi, start, done_clr;

    assign start    = wr && (PADDR == OFF_CNT) && !busy && (PWDATA[5:0] != 6'd0);
    assign done_clr = rd && (PADDR == OFF_DATA);

    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            out_q  <= '0;
            dir_q  <= '0;
            pin_s1 <= '0;
            pin_s2 <= '0;
            tx_q   <= 32'd0;
        end else begin
            pin_s1 <= pad_in;
            pin_s2 <= pin_s1;
            if (wr && PADDR == OFF_OUT)           out_q <= PWDATA[PAD_W-1:0];
            if (wr && PADDR == OFF_DIR)           dir_q <= PWDATA[PAD_W-1:0];
            if (wr && PADDR == OFF_DATA && !busy) tx_q  <= PWDATA;
        end
    end

`ifdef APB_SD_SPI_CLKDIV_EN
    logic [7:0] div_q;
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n)                    div_q <= 8'hFF;
        else if (wr && PADDR == OFF_DIV && !busy) div_q <= PWDATA[7:0];
    end
    assign div = div_q;
`else
    assign div = 8'd0;
`endif

    spi_shift_engine u_engine (
        .clk       (clk),
        .rst_n     (cpu_reset_n),
        .start     (start),
        .n         (clamp_cnt(PWDATA[5:0])),
        .tx        (tx_q),
        .div       (div),
        .done_clr  (done_clr),
        .miso      (pad_in[PAD_MISO]),
        .busy      (busy),
        .done      (done),
        .rx        (rx),
        .sck       (sck),
        .mosi      (mosi),
        .remaining (remaining),
        .state     (eng_state)
    );

    always_comb begin
        PRDATA = 32'hFFFF_FFFF;
        if (rd) begin
            case (PADDR)
                OFF_OUT:    PRDATA = {{ZW{1'b0}}, out_q};
                OFF_DIR:    PRDATA = {{ZW{1'b0}}, dir_q};
                OFF_PIN:    PRDATA = {{ZW{1'b0}}, pin_s2};
                OFF_DATA:   PRDATA = rx;
                OFF_CNT:    PRDATA = {26'd0, remaining};
                OFF_STATUS: PRDATA = {30'd0, done, busy};
`ifdef APB_SD_SPI_CLKDIV_EN
                OFF_DIV:    PRDATA = {24'd0, div};
`endif
                default:    PRDATA = 32'hFFFF_FFFF;
            endcase
        end
    end

    // The engine owns SCK/MOSI for the whole transfer; CS stays software-driven.
    always_comb begin
        pad_out = out_q;
        pad_oe  = dir_q;
        if (busy) begin
            pad_out[PAD_SCK]  = sck;
            pad_out[PAD_MOSI] = mosi;
            pad_oe[PAD_SCK]   = 1'b1;
            pad_oe[PAD_MOSI]  = 1'b1;
        end
    end

    busy_matches_state: assert property (@(posedge clk) disable iff (!cpu_reset_n)
        busy == (eng_state != ST_IDLE));

endmodule

// File: tb/tb_apb_sd_spi.sv
// Self-checking bench for apb_sd_spi: register table, loopback transfers
// against a bit-level reference model, and multi-cycle corner sequences.
module tb_apb_sd_spi;

    logic        clk = 1'b0;
    logic        cpu_reset_n;
    logic [7:0]  PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY;
    logic [5:0]  pad_out, pad_oe, pad_in, pad_in_drv;
    logic        loop_en;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rx = 32'd0;
    int          h_cur = 1;

    assign pad_in = {pad_in_drv[5:1], loop_en ? pad_out[1] : pad_in_drv[0]};

    apb_sd_spi #(.PAD_W(6)) dut (
        .clk         (clk),
        .cpu_reset_n (cpu_reset_n),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .pad_out     (pad_out),
        .pad_oe      (pad_oe),
        .pad_in      (pad_in)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(negedge clk);
        PENABLE = 1'b1;
        @(posedge clk);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(negedge clk);
        PENABLE = 1'b1;
        #1;
        data = PRDATA;
        @(posedge clk);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wait_idle(output int busy_cyc, output int pulses, output logic timed_out);
        logic prev = 1'b0;
        busy_cyc = 0; pulses = 0; timed_out = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!pad_oe[2]) begin
                timed_out = 1'b0;
                break;
            end
            busy_cyc++;
            if (pad_out[2] && !prev) pulses++;
            prev = pad_out[2];
        end
    endtask

    // reference model: the N low bits of TXDATA come back right-aligned
    function automatic logic [31:0] model_rx(input logic [31:0] tx, input int n, input logic [31:0] prev);
        if (n == 0) return prev;
        if (n >= 32) return tx;
        return tx & ((32'h1 << n) - 32'h1);
    endfunction

    task automatic xfer_and_check(input logic [31:0] tx, input int n_raw);
        int n, busy_cyc, pulses;
        logic to;
        logic [31:0] rd;
        n = (n_raw > 32) ? 32 : n_raw;
        last_rx = model_rx(tx, n, last_rx);
        exp_q.push_back(last_rx);
        apb_write(8'h4C, tx);
        apb_write(8'h50, n_raw);
        wait_idle(busy_cyc, pulses, to);
        check("xfer_timeout", {31'd0, to}, 32'd0);
        check("busy_cycles", busy_cyc, 2 * h_cur * n);
        check("sck_pulses", pulses, n);
        apb_read(8'h54, rd);
        check("status_after", rd, (n > 0) ? 32'd2 : 32'd0);
        apb_read(8'h50, rd);
        check("cnt_after", rd, 32'd0);
        apb_read(8'h4C, rd);
        check("rxdata", rd, exp_q.pop_front());
        apb_read(8'h54, rd);
        check("status_cleared", rd, 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [31:0] rd;
        int busy_cyc, pulses;
        logic to;

        tbl[0]  = '{1'b0, 8'h40, 32'd0, 32'h0000_0000};
        tbl[1]  = '{1'b0, 8'h44, 32'd0, 32'h0000_0000};
        tbl[2]  = '{1'b0, 8'h54, 32'd0, 32'h0000_0000};
        tbl[3]  = '{1'b0, 8'h50, 32'd0, 32'h0000_0000};
        tbl[4]  = '{1'b0, 8'h4C, 32'd0, 32'h0000_0000};
        tbl[5]  = '{1'b0, 8'h48, 32'd0, 32'h0000_0000};
        tbl[6]  = '{1'b0, 8'h60, 32'd0, 32'hFFFF_FFFF};
        tbl[7]  = '{1'b0, 8'h00, 32'd0, 32'hFFFF_FFFF};
        tbl[8]  = '{1'b1, 8'h40, 32'hFFFF_FFFF, 32'd0};
        tbl[9]  = '{1'b0, 8'h40, 32'd0, 32'h0000_003F};
        tbl[10] = '{1'b1, 8'h44, 32'h1234_5678, 32'd0};
        tbl[11] = '{1'b0, 8'h44, 32'd0, 32'h0000_0038};
        tbl[12] = '{1'b1, 8'h40, 32'h0000_0008, 32'd0};
        tbl[13] = '{1'b1, 8'h44, 32'h0000_0008, 32'd0};
        tbl[14] = '{1'b0, 8'h40, 32'd0, 32'h0000_0008};
        tbl[15] = '{1'b0, 8'h44, 32'd0, 32'h0000_0008};

        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'd0; PWDATA = 32'd0;
        pad_in_drv = 6'd0; loop_en = 1'b0;
        cpu_reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pad_out", {26'd0, pad_out}, 32'd0);
        check("reset_pad_oe", {26'd0, pad_oe}, 32'd0);
        check("reset_prdata_idle", PRDATA, 32'hFFFF_FFFF);
        cpu_reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) begin
                apb_write(tbl[i].addr, tbl[i].data);
            end else begin
                apb_read(tbl[i].addr, rd);
                check($sformatf("table_%0d_addr_%h", i, tbl[i].addr), rd, tbl[i].exp);
            end
        end

        @(negedge clk);
        check("cs_pad_oe", {26'd0, pad_oe}, 32'h08);
        check("cs_pad_out", {26'd0, pad_out}, 32'h08);

        apb_write(8'h50, 32'd0);
        @(negedge clk);
        check("cnt0_no_busy", {31'd0, pad_oe[2]}, 32'd0);
        apb_read(8'h54, rd);
        check("cnt0_status", rd, 32'd0);

`ifdef APB_SD_SPI_CLKDIV_EN
        apb_read(8'h58, rd);
        check("div_reset", rd, 32'h0000_00FF);
        apb_write(8'h58, 32'd0);
        apb_read(8'h58, rd);
        check("div_zero", rd, 32'd0);
`else
        apb_read(8'h58, rd);
        check("div_unmapped", rd, 32'hFFFF_FFFF);
`endif
        h_cur = 1;

        // PIN latency: read held open while pad_in changes
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h48;
        pad_in_drv = 6'h2A;
        #1 check("pin_lat0", PRDATA, 32'h00);
        @(negedge clk);
        #1 check("pin_lat1", PRDATA, 32'h00);
        @(negedge clk);
        #1 check("pin_lat2", PRDATA, 32'h2A);
        PSEL = 1'b0; PENABLE = 1'b0;
        pad_in_drv = 6'd0;
        loop_en = 1'b1;

        xfer_and_check(32'h0000_00A5, 8);
        xfer_and_check(32'hDEAD_BEEF, 32);
        xfer_and_check(32'hDEAD_BEEF, 40);
        xfer_and_check(32'hFFFF_FFFF, 1);

        for (int i = 0; i < 12; i++) begin
            xfer_and_check($urandom, $urandom_range(0, 40));
        end

        // CNT and TXDATA writes during a transfer are ignored
        last_rx = 32'h0000_00A5;
        exp_q.push_back(last_rx);
        apb_write(8'h4C, 32'h0000_00A5);
        apb_write(8'h50, 32'd8);
        apb_write(8'h50, 32'd4);
        apb_write(8'h4C, 32'd0);
        wait_idle(busy_cyc, pulses, to);
        check("ignore_timeout", {31'd0, to}, 32'd0);
        check("ignore_busy_left", busy_cyc, 12);
        apb_read(8'h54, rd);
        check("ignore_status", rd, 32'd2);
        apb_read(8'h4C, rd);
        check("ignore_rxdata", rd, exp_q.pop_front());

`ifdef APB_SD_SPI_CLKDIV_EN
        apb_write(8'h58, 32'd3);
        h_cur = 4;
        xfer_and_check($urandom, 4);
        apb_write(8'h58, 32'd0);
        h_cur = 1;
`endif

        // reset during bit 3 aborts at once
        apb_write(8'h4C, 32'hFFFF_FFFF);
        apb_write(8'h50, 32'd8);
        repeat (7) @(negedge clk);
        check("busy_before_reset", {31'd0, pad_oe[2]}, 32'd1);
        cpu_reset_n = 1'b0;
        #1;
        check("abort_pad_out", {26'd0, pad_out}, 32'd0);
        check("abort_pad_oe", {26'd0, pad_oe}, 32'd0);
        repeat (2) @(negedge clk);
        cpu_reset_n = 1'b1;
        apb_read(8'h54, rd);
        check("abort_status", rd, 32'd0);
        apb_read(8'h4C, rd);
        check("abort_rxdata", rd, 32'd0);
        apb_read(8'h40, rd);
        check("abort_out", rd, 32'd0);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
